// File: rtl/pipeline_if_pkg.sv
// pipeline_if_pkg: shared definitions for the byte-serial instruction fetch
// stage. Holds bus widths, the NOP word, the IF/ID bit position inside the
// pipeline stall/flush vectors, the FSM state encoding and small helpers
// that map FSM states onto byte offsets.
package pipeline_if_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PIPE_W  = 5;
  localparam int unsigned IFID_B  = 1;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  // S_A0..S_A3 issue byte k; the low two bits of those encodings are k.
  typedef enum logic [2:0] {
    S_A0   = 3'd0,
    S_A1   = 3'd1,
    S_A2   = 3'd2,
    S_A3   = 3'd3,
    S_LAST = 3'd4,
    S_HOLD = 3'd5
  } if_state_e;

  function automatic logic is_issue(input if_state_e s);
    logic [2:0] v;
    v = s;
    return (v[2] == 1'b0);
  endfunction

  function automatic logic [1:0] byte_off(input if_state_e s);
    logic [2:0] v;
    v = s;
    return v[1:0];
  endfunction

  function automatic if_state_e next_issue(input if_state_e s);
    case (s)
      S_A0:    return S_A1;
      S_A1:    return S_A2;
      S_A2:    return S_A3;
      default: return S_LAST;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_if.sv
// pipeline_if: instruction fetch stage reading each 32-bit instruction as
// four little-endian byte reads over a shared byte memory port.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   rdy         global ready; low freezes every register and the request
//   mem_busy_i  byte port owned by MEM this cycle, no request may issue
//   mem_re_o    byte read request
//   mem_addr_o  byte address of the request
//   mem_data_i  read byte, returned one cycle after an accepted request
//   br_e_i      redirect from EX (wins over stall and completion)
//   br_addr_i   redirect target, any alignment
//   stall_i     stall vector, bit 1 holds the IF/ID register
//   flush_i     flush vector, bit 1 bubbles the IF/ID register
//   inst_o      registered instruction to ID
//   pc_o        registered PC of inst_o
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              mem_busy_i,
  output logic              mem_re_o,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic [BYTE_W-1:0] mem_data_i,
  input  logic              br_e_i,
  input  logic [XLEN-1:0]   br_addr_i,
  input  logic [PIPE_W-1:0] stall_i,
  input  logic [PIPE_W-1:0] flush_i,
  output logic [XLEN-1:0]   inst_o,
  output logic [XLEN-1:0]   pc_o
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pco_q, pco_d;
  logic            infl_q, infl_d;
  logic [1:0]      idx_q, idx_d;
  logic [XLEN-1:0] done_word;
  logic            deliver;
  logic            ifid_hold;
  logic            ifid_flush;
  logic            unused_pipe_bits;

  assign ifid_hold        = stall_i[IFID_B];
  assign ifid_flush       = flush_i[IFID_B];
  assign unused_pipe_bits = ^{stall_i[4:2], stall_i[0], flush_i[4:2], flush_i[0]};

  // The request is combinational on mem_busy_i so a free port is used in the
  // same cycle; a redirect suppresses it because that byte would be dropped.
  always_comb begin
    mem_re_o   = rst & rdy & ~br_e_i & ~mem_busy_i & is_issue(state_q);
    mem_addr_o = '0;
    if (rst)
      mem_addr_o = pc_q + {{(XLEN-2){1'b0}}, byte_off(state_q)};
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    word_d    = word_q;
    inst_d    = inst_q;
    pco_d     = pco_q;
    infl_d    = infl_q;
    idx_d     = idx_q;
    deliver   = 1'b0;
    done_word = word_q;
    if (rdy) begin
      // The returning byte lands whatever the port is doing this cycle.
      if (infl_q) begin
        word_d[{idx_q, 3'b000} +: BYTE_W] = mem_data_i;
        infl_d                            = 1'b0;
      end
      // Byte 3 is only on mem_data_i now, so splice it in directly.
      if (state_q == S_LAST)
        done_word = {mem_data_i, word_q[23:0]};
      if (br_e_i) begin
        pc_d    = br_addr_i;
        state_d = S_A0;
        infl_d  = 1'b0;
      end else if (is_issue(state_q)) begin
        if (!mem_busy_i) begin
          infl_d  = 1'b1;
          idx_d   = byte_off(state_q);
          state_d = next_issue(state_q);
        end
      end else if (!ifid_hold) begin
        deliver = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = S_A0;
      end else begin
        word_d  = done_word;
        state_d = S_HOLD;
      end
      if (!ifid_hold) begin
        inst_d = deliver ? done_word : NOP_WORD;
        pco_d  = pc_q;
      end
      if (ifid_flush)
        inst_d = NOP_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_A0;
      pc_q    <= RESET_PC;
      word_q  <= '0;
      inst_q  <= NOP_WORD;
      pco_q   <= RESET_PC;
      infl_q  <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
      infl_q  <= infl_d;
      idx_q   <= idx_d;
    end
  end

  assign inst_o = inst_q;
  assign pc_o   = pco_q;

endmodule
